// File: rtl/fire5_expand3_writer.sv
// Serialises one parallel expand3 ofm sample into the activation RAM, one word
// per cycle, channel-major, after the expand1 channels; flags done after the last pixel.
//   state   | meaning
//   S_IDLE  | waiting for a sample
//   S_DRAIN | writing shadow[ch_cnt] each cycle
//   S_DONE  | every pixel written; terminal until rst
module fire5_expand3_writer #(
  parameter int DSP_NO  = 128,
  parameter int WIDTH   = 16,
  parameter int WOUT    = 32,
  parameter int CH_BASE = 128,
  parameter int ADDR_W  = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fire5_expand3_sample,
  input  logic [WIDTH-1:0]  ofm [0:DSP_NO-1],
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [WIDTH-1:0]  ram_data,
  output logic              busy,
  output logic              overrun,
  output logic              ram_feedback
);

  localparam int NPIX  = WOUT * WOUT;
  localparam int CH_W  = (DSP_NO > 1) ? $clog2(DSP_NO) : 1;
  localparam int PIX_W = $clog2(NPIX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  logic [CH_W-1:0]   r_ch_cnt;
  logic [PIX_W-1:0]  r_pix_cnt;
  logic [WIDTH-1:0]  r_shadow [0:DSP_NO-1];

  logic              w_last_ch;
  logic [PIX_W-1:0]  w_pix_next;
  logic [ADDR_W-1:0] w_addr;

  assign w_last_ch  = (r_ch_cnt == CH_W'(DSP_NO - 1));
  assign w_pix_next = r_pix_cnt + PIX_W'(1);
  // Full-width product so the channel offset never truncates.
  assign w_addr = (ADDR_W'(CH_BASE) + ADDR_W'(r_ch_cnt)) * ADDR_W'(NPIX)
                  + ADDR_W'(r_pix_cnt);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ch_cnt     <= '0;
      r_pix_cnt    <= '0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_data     <= '0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      ram_feedback <= 1'b0;
      for (int i = 0; i < DSP_NO; i++) r_shadow[i] <= '0;
    end else begin
      ram_we <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fire5_expand3_sample) begin
            for (int i = 0; i < DSP_NO; i++) r_shadow[i] <= ofm[i];
            r_ch_cnt <= '0;
            r_state  <= S_DRAIN;
            busy     <= 1'b1;
          end
        end
        S_DRAIN: begin
          ram_we   <= 1'b1;
          ram_data <= r_shadow[r_ch_cnt];
          ram_addr <= w_addr;
          if (w_last_ch) begin
            r_pix_cnt <= w_pix_next;
            r_ch_cnt  <= '0;
            if (w_pix_next == PIX_W'(NPIX)) begin
              r_state <= S_DONE;
              busy    <= 1'b0;
            end else if (fire5_expand3_sample) begin
              // Re-capture on the last channel keeps writes back-to-back.
              for (int i = 0; i < DSP_NO; i++) r_shadow[i] <= ofm[i];
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end else begin
            r_ch_cnt <= r_ch_cnt + CH_W'(1);
            if (fire5_expand3_sample) overrun <= 1'b1;
          end
        end
        S_DONE: begin
          ram_feedback <= 1'b1;
          busy         <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fire5_expand3_writer.sv
// Scoreboard bench: default-size DUT for burst/overrun/reset behaviour and a
// small-layer DUT for the end-of-layer done flag.
module tb_fire5_expand3_writer;

  localparam int DSP_NO = 128, WIDTH = 16, WOUT = 32, CH_BASE = 128, ADDR_W = 18;
  localparam int NPIX = WOUT * WOUT;
  localparam int SD = 8, SW = 4, SB = 8, SA = 8;
  localparam int SNPIX = SW * SW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic              sample = 1'b0;
  logic [WIDTH-1:0]  ofm [0:DSP_NO-1];
  logic              ram_we, busy, overrun, ram_feedback;
  logic [ADDR_W-1:0] ram_addr;
  logic [WIDTH-1:0]  ram_data;

  logic              s_sample = 1'b0;
  logic [WIDTH-1:0]  s_ofm [0:SD-1];
  logic              s_we, s_busy, s_overrun, s_fb;
  logic [SA-1:0]     s_addr;
  logic [WIDTH-1:0]  s_data;

  fire5_expand3_writer #(.DSP_NO(DSP_NO), .WIDTH(WIDTH), .WOUT(WOUT),
                         .CH_BASE(CH_BASE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .fire5_expand3_sample(sample), .ofm(ofm),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .overrun(overrun), .ram_feedback(ram_feedback));

  fire5_expand3_writer #(.DSP_NO(SD), .WIDTH(WIDTH), .WOUT(SW),
                         .CH_BASE(SB), .ADDR_W(SA)) dut_s (
    .clk(clk), .rst(rst), .fire5_expand3_sample(s_sample), .ofm(s_ofm),
    .ram_we(s_we), .ram_addr(s_addr), .ram_data(s_data),
    .busy(s_busy), .overrun(s_overrun), .ram_feedback(s_fb));

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  exp_t me, se;
  int checks = 0, errors = 0;
  int busy_cnt = 0, run = 0, max_run = 0;
  int pix = 0, spix = 0;

  always @(negedge clk) begin
    if (ram_we) begin
      run++;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL main_write: got addr=%0d data=%h, expected no write", ram_addr, ram_data);
      end else begin
        me = q.pop_front();
        if (me.addr != 32'(ram_addr) || me.data != ram_data) begin
          errors++;
          $display("FAIL main_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   ram_addr, ram_data, me.addr, me.data);
        end
      end
    end else begin
      run = 0;
    end
    if (run > max_run) max_run = run;
    if (busy) busy_cnt++;
  end

  always @(negedge clk) begin
    if (s_we) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL small_write: got addr=%0d data=%h, expected no write", s_addr, s_data);
      end else begin
        se = sq.pop_front();
        if (se.addr != 32'(s_addr) || se.data != s_data) begin
          errors++;
          $display("FAIL small_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                   s_addr, s_data, se.addr, se.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drives a sample for one cycle starting at the next falling edge; nexp is
  // how many of its channel writes are expected to appear.
  task automatic issue(input logic [15:0] base, input int nexp);
    @(negedge clk);
    sample = 1'b1;
    for (int i = 0; i < DSP_NO; i++) begin
      ofm[i] = base + 16'(i);
      if (i < nexp)
        q.push_back('{addr: 32'((CH_BASE + i) * NPIX + pix), data: base + 16'(i)});
    end
    if (nexp > 0) pix++;
  endtask

  task automatic s_issue(input int nexp);
    @(negedge clk);
    s_sample = 1'b1;
    for (int i = 0; i < SD; i++) begin
      s_ofm[i] = 16'h4000 + 16'(spix * 16 + i);
      if (i < nexp)
        sq.push_back('{addr: 32'((SB + i) * SNPIX + spix),
                       data: 16'h4000 + 16'(spix * 16 + i)});
    end
    if (nexp > 0) spix++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      sample   = 1'b0;
      s_sample = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < DSP_NO; i++) ofm[i] = '0;
    for (int i = 0; i < SD; i++) s_ofm[i] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_we", ram_we, 0);
    chk("rst_addr", ram_addr, 0);
    chk("rst_data", ram_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_feedback", ram_feedback, 0);
    @(negedge clk);
    rst = 1'b0;

    // Single sample: latency, busy width
    busy_cnt = 0;
    issue(16'd1, 128);
    idle(1);
    chk("t1_no_write_at_capture", ram_we, 0);
    chk("t1_busy_rise", busy, 1);
    @(posedge clk);
    #1;
    chk("t1_first_we", ram_we, 1);
    chk("t1_first_addr", ram_addr, 131072);
    chk("t1_first_data", ram_data, 1);
    idle(287);
    chk("t1_busy_cycles", busy_cnt, 128);
    chk("t1_overrun", overrun, 0);
    chk("t1_drained", q.size(), 0);

    // Second pixel
    issue(16'h8000, 128);
    idle(288);
    chk("t2_drained", q.size(), 0);
    chk("t2_overrun", overrun, 0);

    // Back-to-back capture on the last channel
    busy_cnt = 0;
    max_run  = 0;
    issue(16'h1000, 128);
    idle(127);
    issue(16'h2000, 128);
    idle(200);
    chk("t3_run_length", max_run, 256);
    chk("t3_busy_cycles", busy_cnt, 256);
    chk("t3_overrun", overrun, 0);
    chk("t3_drained", q.size(), 0);

    // Sample at ch_cnt=5 is dropped
    issue(16'h3000, 128);
    idle(5);
    issue(16'hDE00, 0);
    idle(1);
    chk("t4_overrun_set", overrun, 1);
    idle(200);
    chk("t4_overrun_sticky", overrun, 1);
    chk("t4_drained", q.size(), 0);
    chk("t4_busy_low", busy, 0);

    // Reset mid-drain at ch_cnt=60
    issue(16'h5000, 60);
    idle(60);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_we", ram_we, 0);
    chk("t6_busy", busy, 0);
    chk("t6_feedback", ram_feedback, 0);
    chk("t6_overrun_cleared", overrun, 0);
    @(negedge clk);
    rst = 1'b0;
    pix = 0;
    chk("t6_partial_drained", q.size(), 0);
    issue(16'h6000, 128);
    idle(1);
    @(posedge clk);
    #1;
    chk("t6_restart_addr", ram_addr, 131072);
    idle(200);
    chk("t6_drained", q.size(), 0);

    // Full layer on the small instance
    for (int k = 0; k < SNPIX - 1; k++) begin
      s_issue(SD);
      idle(19);
    end
    s_issue(SD);
    idle(1);
    repeat (SD) @(posedge clk);
    #1;
    chk("t5_last_we", s_we, 1);
    chk("t5_last_addr", s_addr, 255);
    chk("t5_fb_not_yet", s_fb, 0);
    @(posedge clk);
    #1;
    chk("t5_fb_set", s_fb, 1);
    chk("t5_we_after", s_we, 0);
    chk("t5_busy_after", s_busy, 0);
    s_issue(0);
    idle(20);
    chk("t5_overrun", s_overrun, 0);
    chk("t5_fb_sticky", s_fb, 1);
    chk("t5_drained", sq.size(), 0);
    chk("main_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
